pipe_stage_buf: RTL and testbench

Parametrised pipeline stage buffer with a valid/ready handshake on both sides, used between any two adjacent core stages (IF→ID, ID→EX, EX→MEM, MEM→WB). It generalises the fixed-width IF→ID register:
- configurable payload width and reset payload;
- three build-time modes: half-throughput single entry, full-throughput two-entry skid buffer, and combinational pass-through for the single-cycle build;
- synchronous flush for branch/exception squash;
- occupancy output for performance counters.

---
 rtl/pipe_stage_buf_if.sv | 13 +
 rtl/pipe_stage_buf.sv | 121 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready payload channel between two adjacent pipeline stages.
// A beat transfers on the posedge where valid & ready are both high; until then the
// master keeps valid high and data unchanged, and ready never waits on valid.
interface pipe_stage_buf_if #(
  parameter int WIDTH = 96
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: single entry (MODE 0), two-entry skid (MODE 1) or
// combinational pass-through (MODE 2), with synchronous flush and occupancy count.
module pipe_stage_buf #(
  parameter int               WIDTH      = 96,
  parameter logic [WIDTH-1:0] RESET_DATA = WIDTH'({32'h80000000, 64'h0}),
  parameter int               MODE       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_buf_if.slave      s,
  pipe_stage_buf_if.master     m,
  output logic [1:0]           count
);

  if (MODE == 2) begin : g_pass
    assign m.valid = s.valid & ~flush;
    assign m.data  = s.data;
    assign s.ready = m.ready;
    assign count   = 2'd0;

  end else if (MODE == 0) begin : g_single
    logic             main_v_q, main_v_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             s_xfer, m_xfer;

    // Accept only into an empty entry, so in and out never overlap: half rate.
    assign s.ready = ~main_v_q & ~rst;
    assign m.valid = main_v_q;
    assign m.data  = main_q;
    assign count   = {1'b0, main_v_q};

    assign s_xfer = s.valid & s.ready;
    assign m_xfer = main_v_q & m.ready;

    always_comb begin
      main_v_d = main_v_q;
      main_d   = main_q;
      if (flush) begin
        main_v_d = 1'b0;
      end else if (s_xfer) begin
        main_d   = s.data;
        main_v_d = 1'b1;
      end else if (m_xfer) begin
        main_v_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        main_v_q <= 1'b0;
        main_q   <= RESET_DATA;
      end else begin
        main_v_q <= main_v_d;
        main_q   <= main_d;
      end
    end

  end else begin : g_skid
    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             s_xfer, m_xfer;

    // s_ready comes from registered state only; the skid slot absorbs the beat
    // that was already in flight when m_ready dropped.
    assign s.ready = ~skid_v_q & ~rst;
    assign m.valid = main_v_q;
    assign m.data  = main_q;
    assign count   = {1'b0, main_v_q} + {1'b0, skid_v_q};

    assign s_xfer = s.valid & s.ready;
    assign m_xfer = main_v_q & m.ready;

    always_comb begin
      main_v_d = main_v_q;
      skid_v_d = skid_v_q;
      main_d   = main_q;
      skid_d   = skid_q;
      if (flush) begin
        main_v_d = 1'b0;
        skid_v_d = 1'b0;
      end else begin
        if (m_xfer) begin
          if (skid_v_q) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
          end else begin
            main_v_d = 1'b0;
          end
        end
        // s_xfer implies the skid slot is empty, so this never clobbers skid data.
        if (s_xfer) begin
          if (!main_v_q || (m_xfer && !skid_v_q)) begin
            main_d   = s.data;
            main_v_d = 1'b1;
          end else begin
            skid_d   = s.data;
            skid_v_d = 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        main_v_q <= 1'b0;
        skid_v_q <= 1'b0;
        main_q   <= RESET_DATA;
        skid_q   <= '0;
      end else begin
        main_v_q <= main_v_d;
        skid_v_q <= skid_v_d;
        main_q   <= main_d;
        skid_q   <= skid_d;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: one instance per MODE, each checked every cycle against
// a queue-based model of the buffer contents, plus directed scenarios.
module tb_pipe_stage_buf;
  localparam int W = 96;
  localparam logic [W-1:0] RST_DATA = {32'h80000000, 64'h0};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic flush0, flush1, flush2;
  logic [1:0] count0, count1, count2;

  pipe_stage_buf_if #(.WIDTH(W)) s0_if ();
  pipe_stage_buf_if #(.WIDTH(W)) m0_if ();
  pipe_stage_buf_if #(.WIDTH(W)) s1_if ();
  pipe_stage_buf_if #(.WIDTH(W)) m1_if ();
  pipe_stage_buf_if #(.WIDTH(W)) s2_if ();
  pipe_stage_buf_if #(.WIDTH(W)) m2_if ();

  pipe_stage_buf #(.WIDTH(W), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .s(s0_if), .m(m0_if), .count(count0));
  pipe_stage_buf #(.WIDTH(W), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .s(s1_if), .m(m1_if), .count(count1));
  pipe_stage_buf #(.WIDTH(W), .MODE(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush2), .s(s2_if), .m(m2_if), .count(count2));

  // scoreboard: model contents, last head value, observed outputs
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] last0, last1;
  logic [W-1:0] out_log1[$];
  logic         chk_en;
  logic         s0_took, s1_took;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chkb("m1_valid", m1_if.valid, exp_q1.size() != 0);
    chk ("m1_data",  m1_if.data,  (exp_q1.size() != 0) ? exp_q1[0] : last1);
    chki("m1_count", 32'(count1), exp_q1.size());
    chkb("s1_ready", s1_if.ready, !rst && exp_q1.size() < 2);
    chkb("m0_valid", m0_if.valid, exp_q0.size() != 0);
    chk ("m0_data",  m0_if.data,  (exp_q0.size() != 0) ? exp_q0[0] : last0);
    chki("m0_count", 32'(count0), exp_q0.size());
    chkb("s0_ready", s0_if.ready, !rst && exp_q0.size() == 0);
    chkb("m2_valid", m2_if.valid, s2_if.valid & ~flush2);
    chk ("m2_data",  m2_if.data,  s2_if.data);
    chkb("s2_ready", s2_if.ready, m2_if.ready);
    chki("m2_count", 32'(count2), 0);
  endtask

  // One cycle: inputs were set at the negedge; check, cross the posedge, update model.
  task automatic tick();
    logic s1x, m1x, s0x, m0x;
    #1;
    if (chk_en) check_all();
    s1x = s1_if.valid && !rst && exp_q1.size() < 2;
    m1x = (exp_q1.size() != 0) && m1_if.ready;
    s0x = s0_if.valid && !rst && exp_q0.size() == 0;
    m0x = (exp_q0.size() != 0) && m0_if.ready;
    if (m1_if.valid === 1'b1 && m1_if.ready && !flush1 && !rst) out_log1.push_back(m1_if.data);
    @(posedge clk);
    s1_took = s1x;
    s0_took = s0x;
    if (rst) begin
      exp_q1.delete(); exp_q0.delete();
      last1 = RST_DATA; last0 = RST_DATA;
    end else begin
      if (flush1) exp_q1.delete();
      else begin
        if (m1x) void'(exp_q1.pop_front());
        if (s1x) exp_q1.push_back(s1_if.data);
        if (exp_q1.size() != 0) last1 = exp_q1[0];
      end
      if (flush0) exp_q0.delete();
      else begin
        if (m0x) void'(exp_q0.pop_front());
        if (s0x) exp_q0.push_back(s0_if.data);
        if (exp_q0.size() != 0) last0 = exp_q0[0];
      end
    end
    @(negedge clk);
  endtask

  logic [W-1:0] src[3];
  int idx;
  int n_acc;
  logic need0, need1;

  initial begin
    rst = 1'b1; flush0 = 1'b0; flush1 = 1'b0; flush2 = 1'b0;
    s0_if.valid = 1'b0; s0_if.data = '0; m0_if.ready = 1'b0;
    s1_if.valid = 1'b0; s1_if.data = '0; m1_if.ready = 1'b0;
    s2_if.valid = 1'b0; s2_if.data = '0; m2_if.ready = 1'b0;
    chk_en = 1'b0; last0 = RST_DATA; last1 = RST_DATA;
    s0_took = 1'b0; s1_took = 1'b0;

    // reset: two cycles, then release
    @(negedge clk);
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chkb("rst_m1_valid", m1_if.valid, 1'b0);
    chk ("rst_m1_data",  m1_if.data,  96'h80000000_00000000_00000000);
    chkb("rst_s1_ready", s1_if.ready, 1'b1);
    chki("rst_m1_count", 32'(count1), 0);
    chk ("rst_m0_data",  m0_if.data,  96'h80000000_00000000_00000000);

    // streaming MODE 1: one accept and one output per cycle
    out_log1.delete();
    m1_if.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s1_if.valid = 1'b1; s1_if.data = W'(i);
      #1 chkb("stream_s_ready", s1_if.ready, 1'b1);
      tick();
    end
    s1_if.valid = 1'b0;
    tick(); tick();
    chki("stream_out_n", out_log1.size(), 8);
    for (int i = 0; i < out_log1.size() && i < 8; i++) chk("stream_out", out_log1[i], W'(i + 1));

    // back-pressure MODE 1: A, B, C with m_ready low
    out_log1.delete();
    m1_if.ready = 1'b0;
    src[0] = 96'hAAAA_0000_0000_0000_0000_000A;
    src[1] = 96'hBBBB_0000_0000_0000_0000_000B;
    src[2] = 96'hCCCC_0000_0000_0000_0000_000C;
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      s1_if.valid = (idx < 3); s1_if.data = src[idx < 3 ? idx : 2];
      tick();
      if (s1_took) idx++;
    end
    #1;
    chki("bp_count", 32'(count1), 2);
    chkb("bp_s_ready", s1_if.ready, 1'b0);
    chki("bp_c_held", idx, 2);
    m1_if.ready = 1'b1;
    for (int k = 0; k < 10 && !(out_log1.size() == 3 && idx == 3); k++) begin
      s1_if.valid = (idx < 3); s1_if.data = src[idx < 3 ? idx : 2];
      tick();
      if (s1_took) idx++;
    end
    s1_if.valid = 1'b0;
    tick();
    chki("bp_out_n", out_log1.size(), 3);
    for (int i = 0; i < out_log1.size() && i < 3; i++) chk("bp_out_order", out_log1[i], src[i]);

    // flush MODE 1 with two entries held and D offered
    out_log1.delete();
    m1_if.ready = 1'b0;
    s1_if.valid = 1'b1; s1_if.data = 96'hE; tick();
    s1_if.data = 96'hF; tick();
    s1_if.data = 96'hD; flush1 = 1'b1; tick();
    flush1 = 1'b0; s1_if.valid = 1'b0;
    #1;
    chkb("flush_m_valid", m1_if.valid, 1'b0);
    chki("flush_count", 32'(count1), 0);
    m1_if.ready = 1'b1;
    tick(); tick(); tick();
    chki("flush_no_out", out_log1.size(), 0);

    // MODE 0 throughput: alternate-cycle accepts
    m0_if.ready = 1'b1;
    n_acc = 0;
    for (int k = 0; k < 8; k++) begin
      s0_if.valid = 1'b1; s0_if.data = W'(100 + n_acc);
      tick();
      if (s0_took) n_acc++;
    end
    chki("m0_rate", n_acc, 4);
    s0_if.valid = 1'b0;
    tick(); tick();

    // MODE 2 pass-through
    s2_if.valid = 1'b1; s2_if.data = W'(16'h1234);
    for (int i = 0; i < 6; i++) begin
      m2_if.ready = i[0]; flush2 = (i == 4);
      #1;
      chk ("m2_pass_data",  m2_if.data,  96'h1234);
      chkb("m2_pass_ready", s2_if.ready, i[0]);
      chkb("m2_pass_valid", m2_if.valid, i != 4);
      tick();
    end
    flush2 = 1'b0;

    // randomized traffic on all modes, with one reset mid-run
    need0 = 1'b1; need1 = 1'b1;
    for (int c = 0; c < 400; c++) begin
      rst    = (c == 200) || (c == 201);
      flush0 = ($urandom_range(0, 15) == 0);
      flush1 = ($urandom_range(0, 15) == 0);
      flush2 = ($urandom_range(0, 7) == 0);
      m0_if.ready = $urandom_range(0, 3) != 0;
      m1_if.ready = $urandom_range(0, 3) != 0;
      m2_if.ready = $urandom_range(0, 1) != 0;
      if (need0) begin
        s0_if.valid = $urandom_range(0, 2) != 0;
        s0_if.data  = {$urandom, $urandom, $urandom};
      end
      if (need1) begin
        s1_if.valid = $urandom_range(0, 2) != 0;
        s1_if.data  = {$urandom, $urandom, $urandom};
      end
      s2_if.valid = $urandom_range(0, 1) != 0;
      s2_if.data  = {$urandom, $urandom, $urandom};
      tick();
      need0 = s0_took || !s0_if.valid;
      need1 = s1_took || !s1_if.valid;
    end
    rst = 1'b0; flush0 = 1'b0; flush1 = 1'b0; flush2 = 1'b0;
    s0_if.valid = 1'b0; s1_if.valid = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
